tone_gen: RTL

- Consumes the 12-bit note frequency (Hz) produced by the switch/keypad note selector and generates the matching square-wave audio output.
- Computes the half-period in clock cycles, CLK_HZ/(2*freq), with an iterative restoring divider on every frequency change.
- A half-period counter then toggles the audio line; its output drives the audio amp/PWM pin.

---
 rtl/tone_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/tone_gen.sv
// tone_gen: square-wave tone generator with iterative half-period divider
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   tone enable (0 = silence)
//   freq        in   12-bit note frequency in Hz (0 = silence)
//   audio       out  square-wave audio output
//   busy        out  high while the divider runs
//   half_period out  current half-period in clk cycles
module tone_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [11:0]      freq,
    output logic             audio,
    output logic             busy,
    output logic [CNT_W-1:0] half_period
);
    localparam int STEP_W = $clog2(CNT_W);
    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ / 2);

    typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

    state_t             r_state, w_next;
    logic [11:0]        r_freq;
    logic [11:0]        r_rem;
    logic [CNT_W-1:0]   r_quo;
    logic [STEP_W-1:0]  r_step;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_half;
    logic               r_audio;
    logic [12:0]        w_rem_sh;
    logic               w_ge;
    logic [12:0]        w_rem_nx;
    logic [CNT_W-1:0]   w_quo_nx;
    logic               w_last;
    logic               w_wrap;

    // r_quo shifts dividend bits out the top while quotient bits enter at the bottom;
    // the remainder never exceeds the 12-bit divisor, so 12 bits of state suffice
    assign w_rem_sh = {r_rem, r_quo[CNT_W-1]};
    assign w_ge     = w_rem_sh >= {1'b0, r_freq};
    assign w_rem_nx = w_ge ? w_rem_sh - {1'b0, r_freq} : w_rem_sh;
    assign w_quo_nx = {r_quo[CNT_W-2:0], w_ge};
    assign w_last   = r_step == STEP_W'(CNT_W - 1);
    assign w_wrap   = r_cnt == r_half - 1'b1;

    assign audio       = r_audio;
    assign busy        = r_state == DIV;
    assign half_period = r_half;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!en) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:    w_next = freq != 12'd0 ? DIV : IDLE;
                DIV:     w_next = w_last ? RUN : DIV;
                RUN:     w_next = freq == 12'd0 ? IDLE : (freq != r_freq ? DIV : RUN);
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freq  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_half  <= '0;
            r_audio <= 1'b0;
        end else if (w_next == DIV && r_state != DIV) begin
            // audio keeps its level so a retune never glitches
            r_freq <= freq;
            r_rem  <= '0;
            r_quo  <= DIVIDEND;
            r_step <= '0;
            r_cnt  <= '0;
        end else if (w_next == IDLE) begin
            r_audio <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == DIV) begin
            r_quo  <= w_quo_nx;
            r_rem  <= w_rem_nx[11:0];
            r_step <= r_step + 1'b1;
            if (w_last) begin
                r_half <= w_quo_nx == '0 ? CNT_W'(1) : w_quo_nx;
                r_cnt  <= '0;
            end
        end else if (r_state == RUN) begin
            r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
            r_audio <= w_wrap ? ~r_audio : r_audio;
        end
    end
endmodule
